// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: two-port round-robin front end that time-shares one
// four_bit_adder slice. An accepted WIDTH-bit add is processed one nibble
// per clock, least-significant nibble first, with the carry between nibbles
// held in a register. Latency is NIB+2 cycles from grant to next grant.

module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    // Plain 4-bit ripple add with carry in/out.
    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    end

endmodule

module adder_share_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             ci0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             ci1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             done0,
    output logic             done1
);

    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int IW  = $clog2(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic             carry_r;
    logic             owner_r;
    logic             last_r;
    logic [KW-1:0]    k_r;
    logic             win_s;
    logic             accept_s;
    logic [IW-1:0]    base_s;
    logic [3:0]       nib_a_s;
    logic [3:0]       nib_b_s;
    logic [3:0]       nib_sum_s;
    logic             nib_co_s;

    // Select the operand nibble addressed by the current step counter.
    always_comb begin
        base_s  = IW'({k_r, 2'b00});
        nib_a_s = opa_r[base_s +: 4];
        nib_b_s = opb_r[base_s +: 4];
    end

    four_bit_adder u_slice (
        .a  (nib_a_s),
        .b  (nib_b_s),
        .ci (carry_r),
        .s  (nib_sum_s),
        .co (nib_co_s)
    );

    // Round-robin winner, grant strobes and next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        accept_s    = 1'b0;
        win_s       = 1'b0;
        if (req0 && req1) begin
            win_s = ~last_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        case (state_r)
            IDLE: begin
                if (!rst && (req0 || req1)) begin
                    accept_s    = 1'b1;
                    gnt0        = ~win_s;
                    gnt1        = win_s;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (k_r == K_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, nibble-serial accumulation and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_r   <= '0;
            opb_r   <= '0;
            carry_r <= 1'b0;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
            k_r     <= '0;
            sum     <= '0;
            co      <= 1'b0;
            busy    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
        end else begin
            busy  <= (state_nxt_s != IDLE);
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        opa_r   <= win_s ? a1 : a0;
                        opb_r   <= win_s ? b1 : b0;
                        carry_r <= win_s ? ci1 : ci0;
                        owner_r <= win_s;
                        last_r  <= win_s;
                        k_r     <= '0;
                    end else begin
                        k_r <= k_r;
                    end
                end
                RUN: begin
                    sum[base_s +: 4] <= nib_sum_s;
                    carry_r          <= nib_co_s;
                    k_r              <= k_r + K_ONE;
                    if (k_r == K_LAST) begin
                        co    <= nib_co_s;
                        done0 <= ~owner_r;
                        done1 <= owner_r;
                    end else begin
                        co <= co;
                    end
                end
                DONE: begin
                    k_r <= '0;
                end
                default: begin
                    k_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: reset, reset abort, a vector table of
// single operations, round-robin contention and a WIDTH=4 instance.

module tb_adder_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, ci0 = 1'b0, ci1 = 1'b0;
    logic [15:0] a0 = 16'h0000, b0 = 16'h0000, a1 = 16'h0000, b1 = 16'h0000;
    logic        gnt0, gnt1, busy, co, done0, done1;
    logic [15:0] sum;

    logic        w4_req0 = 1'b0, w4_req1 = 1'b0, w4_ci0 = 1'b0, w4_ci1 = 1'b0;
    logic [3:0]  w4_a0 = 4'h0, w4_b0 = 4'h0, w4_a1 = 4'h0, w4_b1 = 4'h0;
    logic        w4_gnt0, w4_gnt1, w4_busy, w4_co, w4_done0, w4_done1;
    logic [3:0]  w4_sum;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] es;
        logic        eco;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    adder_share_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .ci0(ci0),
        .req1(req1), .a1(a1), .b1(b1), .ci1(ci1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .sum(sum), .co(co),
        .done0(done0), .done1(done1)
    );

    adder_share_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0(w4_req0), .a0(w4_a0), .b0(w4_b0), .ci0(w4_ci0),
        .req1(w4_req1), .a1(w4_a1), .b1(w4_b1), .ci1(w4_ci1),
        .gnt0(w4_gnt0), .gnt1(w4_gnt1), .busy(w4_busy), .sum(w4_sum), .co(w4_co),
        .done0(w4_done0), .done1(w4_done1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1 of the grant cycle T; returns at negedge of T+6.
    task automatic do_op(input logic sel, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] es, input logic eco);
        logic oth;
        if (sel) begin
            req1 = 1'b1; a1 = a; b1 = b; ci1 = ci; req0 = 1'b0;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; ci0 = ci; req1 = 1'b0;
        end
        @(negedge clk);
        chk("gnt_own", sel ? gnt1 : gnt0, 32'd1);
        chk("gnt_other", sel ? gnt0 : gnt1, 32'd0);
        chk("busy_at_grant", busy, 32'd0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            oth = ((c % 2) == 1) && (c <= 5);
            if (sel) begin
                req1 = 1'b0; a1 = a ^ 16'h5A5A; b1 = ~b; ci1 = ~ci;
                req0 = oth;  a0 = 16'hDEAD;
            end else begin
                req0 = 1'b0; a0 = a ^ 16'h5A5A; b0 = ~b; ci0 = ~ci;
                req1 = oth;  a1 = 16'hBEEF;
            end
            @(negedge clk);
            chk("busy", busy, 32'(c <= 5));
            chk("done_own", sel ? done1 : done0, 32'(c == 5));
            chk("done_other", sel ? done0 : done1, 32'd0);
            chk("gnt_while_busy", gnt0 | gnt1, 32'd0);
            if (c >= 5) begin
                chk("sum", sum, es);
                chk("co", co, eco);
            end
        end
    endtask

    initial begin
        logic drop0, drop1;

        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[5] = '{1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
        vecs[6] = '{1'b1, 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};

        // Reset with both requests high: no grant, everything cleared.
        req0 = 1'b1; req1 = 1'b1; w4_req0 = 1'b1; w4_req1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", gnt0, 32'd0);
        chk("rst_gnt1", gnt1, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_co", co, 32'd0);
        chk("rst_done", {done1, done0}, 32'd0);
        chk("rst_w4_gnt", {w4_gnt1, w4_gnt0}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; w4_req0 = 1'b0; w4_req1 = 1'b0;

        // Reset abort in the second RUN cycle, held for two cycles.
        @(posedge clk);
        #1;
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h4321; ci0 = 1'b0;
        @(negedge clk);
        chk("abort_gnt0", gnt0, 32'd1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy_before", busy, 32'd1);
        @(posedge clk);
        #1;
        req0 = 1'b1;
        @(negedge clk);
        chk("abort_sum", sum, 32'd0);
        chk("abort_co", co, 32'd0);
        chk("abort_busy", busy, 32'd0);
        chk("abort_done0", done0, 32'd0);
        chk("abort_gnt_in_rst", gnt0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(vecs[0].sel, vecs[0].a, vecs[0].b, vecs[0].ci, vecs[0].es, vecs[0].eco);

        // Remaining table vectors.
        for (int i = 1; i < 7; i++) begin
            @(posedge clk);
            #1;
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].es, vecs[i].eco);
        end

        // Contention: both held high, each drops for one cycle after its grant.
        @(posedge clk);
        #1;
        a0 = 16'h0F0F; b0 = 16'h00F1; ci0 = 1'b1;
        a1 = 16'h8000; b1 = 16'h8000; ci1 = 1'b0;
        drop0 = 1'b0; drop1 = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            req0 = ~drop0;
            req1 = ~drop1;
            @(negedge clk);
            drop0 = gnt0;
            drop1 = gnt1;
            chk("cont_gnt0", gnt0, 32'((c == 0) || (c == 12)));
            chk("cont_gnt1", gnt1, 32'((c == 6) || (c == 18)));
            chk("cont_done0", done0, 32'((c == 5) || (c == 17)));
            chk("cont_done1", done1, 32'((c == 11) || (c == 23)));
            if (done0) begin
                chk("cont_sum0", sum, 32'h1001);
                chk("cont_co0", co, 32'd0);
            end
            if (done1) begin
                chk("cont_sum1", sum, 32'h0000);
                chk("cont_co1", co, 32'd1);
            end
        end
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;

        // WIDTH=4 instance: request held past grant is re-granted at T+3.
        @(posedge clk);
        #1;
        w4_req1 = 1'b1; w4_a1 = 4'h9; w4_b1 = 4'h8; w4_ci1 = 1'b1;
        @(negedge clk);
        chk("w4_gnt_T", w4_gnt1, 32'd1);
        @(posedge clk);
        #1;
        w4_a1 = 4'h0;
        @(negedge clk);
        chk("w4_gnt_T1", w4_gnt1, 32'd0);
        chk("w4_busy_T1", w4_busy, 32'd1);
        chk("w4_done_T1", w4_done1, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w4_done_T2", w4_done1, 32'd1);
        chk("w4_sum_T2", w4_sum, 32'h2);
        chk("w4_co_T2", w4_co, 32'd1);
        chk("w4_gnt_T2", w4_gnt1, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w4_gnt_T3", w4_gnt1, 32'd1);
        chk("w4_busy_T3", w4_busy, 32'd0);
        chk("w4_done_T3", w4_done1, 32'd0);
        @(posedge clk);
        #1;
        w4_req1 = 1'b0; w4_a1 = 4'h9;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w4_done_T5", w4_done1, 32'd1);
        chk("w4_sum_T5", w4_sum, 32'h9);
        chk("w4_co_T5", w4_co, 32'd0);
        chk("w4_done0_never", w4_done0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Sequencer and two-port round-robin arbiter that shares a single `four_bit_adder` slice between two requesters. Each accepted `WIDTH`-bit add runs one nibble per clock, least-significant nibble first, with a registered inter-nibble carry. The block sits between client logic that issues add requests and the shared slice. It trades latency for area against the fully unrolled `sixteen_bit_adder`.

## Interface

**Parameters**
- `WIDTH`, default 16. Operand width in bits; must be a multiple of 4 and at least 4.
- `NIB` is derived as `WIDTH/4`. It is not overridable.

**Ports**
- `clk` input 1. Single clock; all state changes on the rising edge.
- `rst` input 1. Synchronous, active-high reset.
- `req0` input 1. Requester 0 request; held until `gnt0`.
- `a0`, `b0` input `WIDTH`. Requester 0 operands; stable while `req0` is high.
- `ci0` input 1. Requester 0 carry-in.
- `req1`, `a1`, `b1`, `ci1`. Same as requester 0, for requester 1.
- `gnt0`, `gnt1` output 1. Accept strobe; high for exactly the cycle in which the operands are captured.
- `busy` output 1. High while an operation occupies the slice.
- `sum` output `WIDTH`. Result register.
- `co` output 1. Final carry-out register.
- `done0`, `done1` output 1. One-cycle completion pulse to the owning requester.

## Operation

- The internal datapath is one `four_bit_adder` instance. Its inputs are operand nibble k and the carry register; its outputs are sum nibble k and the next carry.
- **State machine:** IDLE, RUN, DONE.
- **IDLE**
  - If neither `req0` nor `req1` is high, stay in IDLE.
  - Otherwise select a winner and assert `gnt<w>` combinationally in this cycle.
  - At the edge: latch `a<w>`, `b<w>` into operand registers, latch `ci<w>` into the carry register, set owner = w, set k = 0, set `last` = w, and go to RUN.
- **Arbitration**
  - With a single request, that requester wins.
  - With both requesting, the requester ≠ `last` wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- **RUN**
  - Each cycle: `sum[4k+3:4k]` ← slice sum, carry ← slice carry-out, k ← k+1.
  - When k == `NIB`-1: `co` ← slice carry-out and go to DONE.
- **DONE**
  - `done<owner>` = 1 for this cycle only.
  - Go to IDLE. No request is accepted in DONE.
- `busy` = 1 in RUN and DONE, 0 in IDLE.
- The `req`/operand inputs of the owner and of the other requester are ignored outside IDLE. A request held through RUN/DONE is arbitrated in the following IDLE cycle.
- **Arithmetic:** {`co`,`sum`} = a + b + ci, computed modulo 2^(`WIDTH`+1). The carry ripples between nibbles only through the carry register.
- `sum` and `co` are valid from the DONE cycle onward. They hold through IDLE until the end of the first RUN cycle of the next operation; lower nibbles are then overwritten progressively.

## Timing

- **Reset values:** state IDLE, `sum` 0, `co` 0, `done0`/`done1` 0, `busy` 0, `last` 1, owner 0, k 0. `gnt0`/`gnt1` are forced to 0 while `rst` is high.
- **Reset mid-operation:** abort immediately. No done pulse is issued, and the result registers return to 0.
- **Latency:** accept in cycle T (`gnt` high) gives RUN in T+1..T+`NIB`, `done` in T+`NIB`+1, and the earliest next `gnt` in T+`NIB`+2.
  - For `WIDTH`=16: `done` at T+5, next `gnt` at T+6.
- **Throughput:** one operation per `NIB`+2 cycles.
- The requester deasserts `req` after sampling `gnt` high. A `req` still high in the cycle after `gnt` is treated as a new request at the next IDLE.
- **Simultaneous events:**
  - `rst` with `req` high: no grant.
  - `done` for one requester and `req` from the other in the same cycle: no grant until the next cycle.

## Test plan

- **Reset abort:** start an op with `req0` and `a0`=16'h1234, then assert `rst` in the 2nd RUN cycle for 2 cycles. Expect `sum`=0, `co`=0, `busy`=0, and no `done0` pulse. The next `req0` is granted in the first cycle after `rst` falls.
- **Basic add:** `req0` with `a0`=16'h1234, `b0`=16'h4321, `ci0`=0. Expect `gnt0` at T, `busy` high T+1..T+5, `done0` at T+5 only, `sum`=16'h5555, `co`=0, and `done1` never asserted.
- **Carry ripple:**
  - `a1`=16'hFFFF, `b1`=16'h0000, `ci1`=1 gives `sum`=16'h0000, `co`=1, `done1` at T+5.
  - `a1`=16'hFFFF, `b1`=16'hFFFF, `ci1`=1 gives `sum`=16'hFFFF, `co`=1.
- **Contention:** hold `req0` and `req1` high continuously, with each requester dropping its `req` for one cycle after its `gnt`. Expect grants of 0,1,0,1 at T, T+6, T+12, T+18. Each `done` goes to the correct requester, and the results match the per-requester operands.
- **Ignored inputs while busy:** change `a0` and toggle `req1` during RUN of a requester-0 operation. Expect the result to use the captured operands, and no `gnt1` until the IDLE cycle.
- **`WIDTH`=4 instance:** `a`=4'h9, `b`=4'h8, `ci`=1. Expect `gnt` at T, `done` at T+2, `sum`=4'h2, `co`=1, and the next `gnt` no earlier than T+3.
